// File: rtl/adf4159_chirp_scheduler.sv
// Steps the ADF4159 driver through a table of frequency profiles and issues chirp triggers.
// Optional busy-wait watchdog: define ADF4159_BUSY_TIMEOUT_EN.
module adf4159_chirp_scheduler #(
  parameter int unsigned PROFILES    = 4,
  parameter int unsigned PRI_WIDTH   = 24,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 65535,
  localparam int unsigned AW         = $clog2(PROFILES)
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  logic                   ipCfgWrite,
  input  logic [AW-1:0]          ipCfgAddr,
  input  logic [11:0]            ipCfgInteger,
  input  logic [24:0]            ipCfgFraction,
  input  logic [COUNT_WIDTH-1:0] ipCfgChirps,
  input  logic [PRI_WIDTH-1:0]   ipPRI,
  input  logic [AW-1:0]          ipLastProfile,
  input  logic                   ipLoop,
  input  logic                   ipStart,
  input  logic                   ipStop,
  output logic [11:0]            opInteger,
  output logic [24:0]            opFraction,
  output logic                   opUpdate,
  input  logic                   ipBusy,
  output logic                   opTrigger,
  output logic                   opRunning,
  output logic [AW-1:0]          opProfile,
  output logic                   opFrameDone,
  output logic                   opError
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE, CHIRP} stateT;

  stateT                  state, nextState;
  logic [AW-1:0]          profile, nextProfile;
  logic [11:0]            integerTab  [PROFILES];
  logic [24:0]            fractionTab [PROFILES];
  logic [COUNT_WIDTH-1:0] chirpTab    [PROFILES];
  logic [COUNT_WIDTH-1:0] chirpsLeft;
  logic [PRI_WIDTH-1:0]   priReg, priCnt, priClamped;
  logic                   stopPending, stopReq, priWrap, advance, frameDoneNext;
  logic                   timeoutHit;

  assign stopReq    = stopPending | ipStop;
  assign priWrap    = (priCnt == priReg - PRI_WIDTH'(1));
  assign priClamped = (ipPRI < PRI_WIDTH'(2)) ? PRI_WIDTH'(2) : ipPRI;

  assign opRunning = (state != IDLE);
  assign opUpdate  = (state == LOAD);
  assign opProfile = profile;
  // A stop arriving in a trigger cycle suppresses that trigger as well.
  assign opTrigger = (state == CHIRP) && (priCnt == '0) && (chirpsLeft != '0) && !stopReq;

`ifdef ADF4159_BUSY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] toCnt;
  logic          errReg;
  logic          inWait;

  assign inWait     = (state == WAIT_ACK) || (state == WAIT_DONE);
  assign timeoutHit = inWait && (toCnt == TW'(TIMEOUT - 1));
  assign opError    = errReg;

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      toCnt  <= '0;
      errReg <= 1'b0;
    end else begin
      toCnt <= inWait ? toCnt + TW'(1) : '0;
      if (state == IDLE && ipStart)
        errReg <= 1'b0;
      else if (timeoutHit)
        errReg <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign opError    = 1'b0;
`endif

  always_comb begin
    nextState     = state;
    nextProfile   = profile;
    advance       = 1'b0;
    frameDoneNext = 1'b0;
    case (state)
      IDLE:      if (ipStart && !ipStop) begin
                   nextState   = LOAD;
                   nextProfile = '0;
                 end
      LOAD:      nextState = WAIT_ACK;
      WAIT_ACK:  if (ipBusy) nextState = WAIT_DONE;
      // The SPI write is never cut short: stop is only honoured once busy drops.
      WAIT_DONE: if (!ipBusy) begin
                   if (stopReq)               nextState = IDLE;
                   else if (chirpsLeft == '0) advance   = 1'b1;
                   else                       nextState = CHIRP;
                 end
      CHIRP:     if (stopReq)                           nextState = IDLE;
                 else if (chirpsLeft == '0 && priWrap)  advance   = 1'b1;
      default:   nextState = IDLE;
    endcase
    if (advance) begin
      if (profile == ipLastProfile) begin
        frameDoneNext = 1'b1;
        if (ipLoop) begin
          nextState   = LOAD;
          nextProfile = '0;
        end else begin
          nextState = IDLE;
        end
      end else begin
        nextState   = LOAD;
        nextProfile = profile + AW'(1);
      end
    end
    if (timeoutHit) begin
      nextState     = IDLE;
      frameDoneNext = 1'b0;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      for (int unsigned i = 0; i < PROFILES; i++) begin
        integerTab[i]  <= '0;
        fractionTab[i] <= '0;
        chirpTab[i]    <= '0;
      end
    end else if (ipCfgWrite) begin
      integerTab[ipCfgAddr]  <= ipCfgInteger;
      fractionTab[ipCfgAddr] <= ipCfgFraction;
      chirpTab[ipCfgAddr]    <= ipCfgChirps;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state       <= IDLE;
      profile     <= '0;
      opInteger   <= '0;
      opFraction  <= '0;
      opFrameDone <= 1'b0;
      chirpsLeft  <= '0;
      priReg      <= '0;
      priCnt      <= '0;
      stopPending <= 1'b0;
    end else begin
      state       <= nextState;
      profile     <= nextProfile;
      opFrameDone <= frameDoneNext;
      // Words are captured on entry so they are valid during the LOAD cycle itself.
      if (nextState == LOAD) begin
        opInteger  <= integerTab[nextProfile];
        opFraction <= fractionTab[nextProfile];
        chirpsLeft <= chirpTab[nextProfile];
      end else if (opTrigger) begin
        chirpsLeft <= chirpsLeft - COUNT_WIDTH'(1);
      end
      if (state == WAIT_DONE && nextState == CHIRP)
        priReg <= priClamped;
      priCnt <= (state == CHIRP && !priWrap) ? priCnt + PRI_WIDTH'(1) : '0;
      if (nextState == IDLE)
        stopPending <= 1'b0;
      else if (ipStop && state != IDLE)
        stopPending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adf4159_chirp_scheduler.sv
// Bench for adf4159_chirp_scheduler: cycle-level reference model plus directed scenarios.
module tb_adf4159_chirp_scheduler;

  localparam int PROFILES = 4;

  logic        ipClk = 1'b0, ipReset = 1'b0, ipCfgWrite = 1'b0;
  logic [1:0]  ipCfgAddr = '0, ipLastProfile = '0;
  logic [11:0] ipCfgInteger = '0;
  logic [24:0] ipCfgFraction = '0;
  logic [15:0] ipCfgChirps = '0;
  logic [23:0] ipPRI = '0;
  logic        ipLoop = 1'b0, ipStart = 1'b0, ipStop = 1'b0, ipBusy = 1'b0;
  logic [11:0] opInteger;
  logic [24:0] opFraction;
  logic        opUpdate, opTrigger, opRunning, opFrameDone, opError;
  logic [1:0]  opProfile;

  adf4159_chirp_scheduler #(.PROFILES(4), .PRI_WIDTH(24), .COUNT_WIDTH(16), .TIMEOUT(65535)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipCfgWrite(ipCfgWrite), .ipCfgAddr(ipCfgAddr),
    .ipCfgInteger(ipCfgInteger), .ipCfgFraction(ipCfgFraction), .ipCfgChirps(ipCfgChirps),
    .ipPRI(ipPRI), .ipLastProfile(ipLastProfile), .ipLoop(ipLoop), .ipStart(ipStart),
    .ipStop(ipStop), .opInteger(opInteger), .opFraction(opFraction), .opUpdate(opUpdate),
    .ipBusy(ipBusy), .opTrigger(opTrigger), .opRunning(opRunning), .opProfile(opProfile),
    .opFrameDone(opFrameDone), .opError(opError)
  );

  always #5 ipClk = ~ipClk;

  int tests = 0, fails = 0, cyc = 0;
  int nTrig = 0, nUpd = 0, nDone = 0;
  int trigT[$];

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a run is a LOAD, a busy handshake, then k = 0.. chirp clocks where a
  // trigger falls on every multiple of P below N*P and the profile ends at k = N*P-1.
  bit          mRun = 0, mAcked = 0, mStop = 0, mFd = 0, newFd, wasRun, stopReq;
  logic [1:0]  mProf = '0;
  logic [11:0] mInt = '0;
  logic [24:0] mFrac = '0;
  int          mN = 0, mP = 2, mK = -1, mAge = 0;
  logic [11:0] tInt  [PROFILES] = '{default: '0};
  logic [24:0] tFrac [PROFILES] = '{default: '0};
  int          tChirp[PROFILES] = '{default: 0};

  task mLoad(input int p);
    mProf = 2'(p); mInt = tInt[p]; mFrac = tFrac[p]; mN = tChirp[p];
    mAge = 0; mAcked = 0; mK = -1;
  endtask

  task mIdle();
    mRun = 0; mK = -1; mStop = 0;
  endtask

  task mAdvance();
    if (mProf == ipLastProfile) begin
      newFd = 1;
      if (ipLoop) mLoad(0);
      else mIdle();
    end else begin
      mLoad((int'(mProf) + 1) % PROFILES);
    end
  endtask

  always @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      mRun = 0; mAcked = 0; mStop = 0; mFd = 0; mProf = '0; mInt = '0; mFrac = '0;
      mN = 0; mP = 2; mK = -1; mAge = 0;
      for (int i = 0; i < PROFILES; i++) begin
        tInt[i] = '0; tFrac[i] = '0; tChirp[i] = 0;
      end
    end else begin
      wasRun = mRun; stopReq = mStop || ipStop; newFd = 0;
      if (!mRun) begin
        if (ipStart && !ipStop) begin mRun = 1; mLoad(0); end
      end else if (mK >= 0) begin
        if (stopReq) mIdle();
        else if (mK == mN * mP - 1) mAdvance();
        else mK++;
      end else if (mAge == 0) begin
        mAge = 1;
      end else if (!mAcked) begin
        if (ipBusy) mAcked = 1;
      end else if (!ipBusy) begin
        if (stopReq) mIdle();
        else if (mN == 0) mAdvance();
        else begin mK = 0; mP = (ipPRI < 2) ? 2 : int'(ipPRI); end
      end
      if (wasRun && mRun && ipStop) mStop = 1;
      mFd = newFd;
      if (ipCfgWrite) begin
        tInt[ipCfgAddr] = ipCfgInteger; tFrac[ipCfgAddr] = ipCfgFraction;
        tChirp[ipCfgAddr] = int'(ipCfgChirps);
      end
    end
  end

  bit          expUpd, expTrig;
  logic [43:0] expV, gotV;

  always @(negedge ipClk) begin
    cyc++;
    expUpd  = mRun && mK < 0 && mAge == 0;
    expTrig = mRun && mK >= 0 && (mK % mP == 0) && (mK / mP < mN) && !mStop && !ipStop;
    expV = {mInt, mFrac, expUpd, expTrig, mRun, mProf, mFd, 1'b0};
    gotV = {opInteger, opFraction, opUpdate, opTrigger, opRunning, opProfile, opFrameDone, opError};
    tests++;
    if (gotV !== expV) begin
      fails++;
      $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, gotV, expV);
    end
    if (opTrigger) begin nTrig++; trigT.push_back(cyc); end
    if (opUpdate) nUpd++;
    if (opFrameDone) nDone++;
  end

  // Driver stand-in: busy for 5 clocks after each update.
  int busyCnt = 0;
  always @(negedge ipClk) begin
    if (!ipReset) begin
      busyCnt = 0; ipBusy = 1'b0;
    end else begin
      if (opUpdate) busyCnt = 5;
      if (busyCnt > 0) begin ipBusy = 1'b1; busyCnt--; end
      else ipBusy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge ipClk); #1;
  endtask

  task automatic cfg(input int a, input int i, input int f, input int c);
    ipCfgWrite = 1'b1; ipCfgAddr = 2'(a); ipCfgInteger = 12'(i);
    ipCfgFraction = 25'(f); ipCfgChirps = 16'(c);
    tick();
    ipCfgWrite = 1'b0;
  endtask

  task automatic pulseStart();
    ipStart = 1'b1; tick(); ipStart = 1'b0;
  endtask

  task automatic clearStats();
    nTrig = 0; nUpd = 0; nDone = 0; trigT.delete();
  endtask

  task automatic waitIdle(input int maxc, input string name);
    int n = 0;
    while (opRunning && n < maxc) begin tick(); n++; end
    check(name, opRunning, 0);
    tick();
  endtask

  initial begin
    int n, t0;
    repeat (3) tick();
    ipReset = 1'b1;
    tick();
    check("reset running", opRunning, 0);
    check("reset integer", opInteger, 0);
    check("reset update", opUpdate, 0);

    // Two profiles, 3 and 2 chirps, PRI 10
    cfg(0, 100, 'h12345, 3);
    cfg(1, 200, 'h1ABCDEF, 2);
    ipPRI = 24'd10; ipLastProfile = 2'd1; ipLoop = 1'b0;
    clearStats(); pulseStart();
    waitIdle(400, "s2 idle");
    check("s2 updates", nUpd, 2);
    check("s2 triggers", nTrig, 5);
    check("s2 framedone", nDone, 1);
    check("s2 integer", opInteger, 200);
    check("s2 profile", opProfile, 1);
    if (trigT.size() == 5) begin
      check("s2 gap p0a", trigT[1] - trigT[0], 10);
      check("s2 gap p0b", trigT[2] - trigT[1], 10);
      check("s2 gap p1", trigT[4] - trigT[3], 10);
    end

    // Zero-chirp profile in the middle is loaded but skipped
    cfg(1, 300, 'hFF, 0);
    cfg(2, 400, 'h1000000, 1);
    ipPRI = 24'd4; ipLastProfile = 2'd2;
    clearStats(); pulseStart();
    waitIdle(400, "s3 idle");
    check("s3 updates", nUpd, 3);
    check("s3 triggers", nTrig, 4);
    check("s3 framedone", nDone, 1);
    check("s3 profile", opProfile, 2);
    check("s3 integer", opInteger, 400);

    // Stop while the SPI write is in flight
    ipLastProfile = 2'd0;
    clearStats(); pulseStart();
    tick(); tick(); tick();
    ipStop = 1'b1; tick(); ipStop = 1'b0;
    check("s4 running busy a", opRunning, 1);
    tick();
    check("s4 running busy b", opRunning, 1);
    tick();
    check("s4 idle after busy", opRunning, 0);
    tick();
    check("s4 triggers", nTrig, 0);
    check("s4 framedone", nDone, 0);
    check("s4 updates", nUpd, 1);

    // PRI below 2 is clamped to 2
    cfg(0, 50, 'h55, 3);
    ipPRI = 24'd0;
    clearStats(); pulseStart();
    waitIdle(200, "s5 idle");
    check("s5 triggers", nTrig, 3);
    check("s5 framedone", nDone, 1);
    if (trigT.size() == 3) begin
      check("s5 gap a", trigT[1] - trigT[0], 2);
      check("s5 gap b", trigT[2] - trigT[1], 2);
    end

    // Start and stop together
    ipStart = 1'b1; ipStop = 1'b1; tick(); ipStart = 1'b0; ipStop = 1'b0;
    check("s5 start+stop", opRunning, 0);
    tick();
    check("s5 start+stop later", opRunning, 0);

    // Looping, then stop in CHIRP
    cfg(0, 60, 'h66, 2);
    ipPRI = 24'd3; ipLoop = 1'b1;
    clearStats(); pulseStart();
    n = 0;
    while (nDone < 2 && n < 300) begin tick(); n++; end
    check("s6 loop frames", nDone >= 2, 1);
    n = 0;
    while (!opTrigger && n < 100) begin tick(); n++; end
    check("s6 trigger seen", opTrigger, 1);
    tick();
    ipStop = 1'b1; tick(); ipStop = 1'b0;
    check("s6 stop in chirp", opRunning, 0);
    t0 = nTrig;
    repeat (10) tick();
    check("s6 no more triggers", nTrig, t0);
    ipLoop = 1'b0;

    // Reset mid-CHIRP
    cfg(0, 'h7AB, 'h1234567, 5);
    ipPRI = 24'd6;
    pulseStart();
    n = 0;
    while (!opTrigger && n < 100) begin tick(); n++; end
    tick(); tick();
    check("s7 integer before reset", opInteger, 'h7AB);
    ipReset = 1'b0;
    #1;
    check("s7 reset running", opRunning, 0);
    check("s7 reset integer", opInteger, 0);
    check("s7 reset fraction", opFraction, 0);
    check("s7 reset trigger", opTrigger, 0);
    tick(); tick();
    ipReset = 1'b1;
    tick();
    check("s7 idle after release", opRunning, 0);
    clearStats(); pulseStart();
    check("s7 cleared table integer", opInteger, 0);
    waitIdle(100, "s7 idle");
    check("s7 updates", nUpd, 1);
    check("s7 triggers", nTrig, 0);
    check("s7 framedone", nDone, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
